// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM state encoding and a constant clog2 helper.
// The optional packet-lock feature is selected by the UART_ARB_LOCK_EN macro in the top.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted bit of valid at or after ptr, wrapping modulo N_REQ.
// Used by uart_tx_arbiter (UART_ARB_LOCK_EN only changes the mask the top feeds in).
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int  N_REQ = 4,
    localparam int IW    = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IW-1:0]    ptr,
    output logic             hit,
    output logic [IW-1:0]    idx
);

    localparam logic [IW:0] N_WIDE = (IW + 1)'(N_REQ);

    always_comb begin
        logic [IW:0] pos;
        hit = 1'b0;
        idx = '0;
        pos = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // One extra bit so ptr + k cannot overflow before the modulo fold.
            pos = {1'b0, ptr} + (IW + 1)'(k);
            if (pos >= N_WIDE) begin
                pos = pos - N_WIDE;
            end
            if (!hit && valid[pos[IW-1:0]]) begin
                hit = 1'b1;
                idx = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART TX core between N_REQ byte sources.
// Define UART_ARB_LOCK_EN to keep the grant on one requester until it sends a byte with req_last=1.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int  N_REQ = 4,
    parameter int  DW    = 8,
    localparam int IW    = clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic [N_REQ-1:0]    req_last,
    output logic [N_REQ-1:0]    req_ready,
    output logic [DW-1:0]       tx_data,
    output logic                tx_start,
    input  logic                tx_ready,
    output logic [IW-1:0]       grant_id,
    output logic                busy
);

    arb_state_t       state;
    logic [IW-1:0]    ptr;
    logic [N_REQ-1:0] eligible;
    logic             hit;
    logic [IW-1:0]    pick_idx;
    logic             accept;
    logic [DW-1:0]    req_bytes [N_REQ];

    function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] g);
        return (g == IW'(N_REQ - 1)) ? '0 : g + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_bytes[i] = req_data[i*DW +: DW];
        end
    end

`ifdef UART_ARB_LOCK_EN
    logic lock;

    // While locked, only the current owner may be granted, so the picker returns it regardless of ptr.
    always_comb begin
        eligible = req_valid;
        if (lock) begin
            eligible = req_valid & (N_REQ'(1) << grant_id);
        end
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign eligible    = req_valid;
`endif

    uart_tx_arbiter_rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .valid (eligible),
        .ptr   (ptr),
        .hit   (hit),
        .idx   (pick_idx)
    );

    // req_ready is the handshake itself: it is high in the IDLE cycle in which the byte is taken.
    assign accept    = !rst && (state == ST_IDLE) && tx_ready && hit;
    assign req_ready = accept ? (N_REQ'(1) << pick_idx) : '0;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            grant_id <= '0;
            ptr      <= '0;
`ifdef UART_ARB_LOCK_EN
            lock     <= 1'b0;
`endif
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        tx_data  <= req_bytes[pick_idx];
                        grant_id <= pick_idx;
                        tx_start <= 1'b1;
                        state    <= ST_START;
`ifdef UART_ARB_LOCK_EN
                        if (req_last[pick_idx]) begin
                            lock <= 1'b0;
                            ptr  <= ptr_after(pick_idx);
                        end else begin
                            lock <= 1'b1;
                        end
`else
                        ptr      <= ptr_after(pick_idx);
`endif
                    end
                end
                ST_START: begin
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!tx_ready) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 115200-baud TX core model (16 clocks per bit at 1.8432 MHz).
// Expected orders for the lock scenario follow UART_ARB_LOCK_EN.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int N_REQ     = 4;
    localparam int DW        = 8;
    localparam int IW        = 2;
    localparam int CPB       = 16;
    localparam int FRAME_CYC = 10 * CPB;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N_REQ-1:0]    req_valid = '0;
    logic [N_REQ*DW-1:0] req_data = '0;
    logic [N_REQ-1:0]    req_last = '0;
    logic [N_REQ-1:0]    req_ready;
    logic [DW-1:0]       tx_data;
    logic                tx_start;
    logic                tx_ready;
    logic [IW-1:0]       grant_id;
    logic                busy;

    uart_tx_arbiter #(
        .N_REQ (N_REQ),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #271 clk = ~clk;

    // TX core model: ready drops the cycle after start, rises again after 10 bit times.
    logic       core_ready = 1'b1;
    logic       hold_busy = 1'b0;
    int         core_cnt = 0;
    logic [9:0] core_frame = '1;
    logic [9:0] rx_shift = '0;
    logic       line;
    logic [9:0] frames[$];

    assign tx_ready = core_ready & ~hold_busy;
    assign line     = core_ready ? 1'b1 : core_frame[4'(core_cnt / CPB)];

    always @(posedge clk) begin
        if (core_ready) begin
            if (tx_start) begin
                core_ready <= 1'b0;
                core_cnt   <= 0;
                core_frame <= {1'b1, tx_data, 1'b0};
            end
        end else begin
            if (core_cnt % CPB == CPB / 2) begin
                rx_shift <= {line, rx_shift[9:1]};
            end
            if (core_cnt == FRAME_CYC - 1) begin
                core_ready <= 1'b1;
                frames.push_back(rx_shift);
            end
            core_cnt <= core_cnt + 1;
        end
    end

    // Monitor: acceptances, starts, one-hot ready and tx_data stability while busy.
    int         cyc = 0;
    int         acc_idx[$];
    int         acc_cyc[$];
    int         st_id[$];
    int         st_data[$];
    int         st_cyc[$];
    int         onehot_err = 0;
    int         stab_err = 0;
    logic [7:0] cur_data = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_ready != '0) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ready[i]) acc_idx.push_back(i);
            end
            acc_cyc.push_back(cyc);
            if (!$onehot(req_ready)) onehot_err <= onehot_err + 1;
        end
        if (tx_start) begin
            st_id.push_back(int'(grant_id));
            st_data.push_back(int'(tx_data));
            st_cyc.push_back(cyc);
            cur_data <= tx_data;
        end else if (busy && !rst && tx_data != cur_data) begin
            stab_err <= stab_err + 1;
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [8:0] pq [N_REQ][$];

    task automatic drive_heads();
        for (int i = 0; i < N_REQ; i++) begin
            if (pq[i].size() > 0) begin
                req_valid[i]            = 1'b1;
                req_data[i*DW +: DW]    = pq[i][0][7:0];
                req_last[i]             = pq[i][0][8];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic clear_logs();
        acc_idx.delete();
        acc_cyc.delete();
        st_id.delete();
        st_data.delete();
        st_cyc.delete();
        frames.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Producers present queue heads; a byte leaves its queue once the edge with req_ready has passed.
    task automatic run_traffic(input string tag, input int n_bytes, input int max_cyc);
        int got;
        int c;
        logic [N_REQ-1:0] accepted;
        got = 0;
        c = 0;
        while (got < n_bytes && c < max_cyc) begin
            drive_heads();
            @(negedge clk);
            accepted = req_ready & req_valid;
            step();
            for (int i = 0; i < N_REQ; i++) begin
                if (accepted[i]) begin
                    void'(pq[i].pop_front());
                    got++;
                end
            end
            c++;
        end
        drive_heads();
        check_val({tag, "_bytes"}, got, n_bytes);
        c = 0;
        while (!(busy == 1'b0 && tx_ready == 1'b1) && c < max_cyc) begin
            step();
            c++;
        end
        check_val({tag, "_idle"}, {busy, tx_ready}, 2'b01);
    endtask

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int stray;
        int c;
        int exp_ord[3];
        int exp_dat[3];

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_tx_start", tx_start, 0);
        check_val("rst_tx_data", tx_data, 0);
        check_val("rst_grant_id", grant_id, 0);
        check_val("rst_busy", busy, 0);
        rst = 1'b0;
        step();

        // 1: single byte from requester 0
        clear_logs();
        pq[0].push_back({1'b1, 8'h55});
        t0 = cyc;
        run_traffic("t1", 1, 400);
        check_val("t1_acc_idx", acc_idx[0], 0);
        check_val("t1_acc_cyc", acc_cyc[0], t0);
        check_val("t1_start_cyc", st_cyc[0], t0 + 1);
        check_val("t1_start_cnt", st_cyc.size(), 1);
        check_val("t1_tx_data", st_data[0], 32'h55);
        check_val("t1_grant_id", st_id[0], 0);
        check_val("t1_frame", frames[0], {1'b1, 8'h55, 1'b0});

        // 2: all four valid, strict rotation from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_logs();
        pq[0].push_back({1'b1, 8'h30});
        pq[0].push_back({1'b1, 8'h30});
        pq[1].push_back({1'b1, 8'h31});
        pq[2].push_back({1'b1, 8'h32});
        pq[3].push_back({1'b1, 8'h33});
        run_traffic("t2", 5, 1500);
        for (int k = 0; k < 5; k++) begin
            check_val($sformatf("t2_order%0d", k), acc_idx[k], k % 4);
            check_val($sformatf("t2_data%0d", k), st_data[k], 32'h30 + (k % 4));
        end
        check_val("t2_b2b_gap", st_cyc[1] - st_cyc[0], FRAME_CYC + 3);

        // 3: core not ready in IDLE holds off the grant
        clear_logs();
        hold_busy = 1'b1;
        pq[1].push_back({1'b1, 8'h77});
        drive_heads();
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (req_ready != '0 || tx_start) stray++;
        end
        step();
        check_val("t3_quiet", stray, 0);
        hold_busy = 1'b0;
        t0 = cyc;
        run_traffic("t3", 1, 400);
        check_val("t3_acc_cyc", acc_cyc[0], t0);
        check_val("t3_start_cyc", st_cyc[0], t0 + 1);
        check_val("t3_grant_id", st_id[0], 1);
        check_val("t3_tx_data", st_data[0], 32'h77);

        // 4: two-byte packet from requester 2 competing with requester 0 (pointer is at 2)
        clear_logs();
`ifdef UART_ARB_LOCK_EN
        exp_ord = '{2, 2, 0};
        exp_dat = '{32'h41, 32'h42, 32'h10};
`else
        exp_ord = '{2, 0, 2};
        exp_dat = '{32'h41, 32'h10, 32'h42};
`endif
        pq[2].push_back({1'b0, 8'h41});
        pq[2].push_back({1'b1, 8'h42});
        pq[0].push_back({1'b1, 8'h10});
        run_traffic("t4", 3, 1000);
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("t4_order%0d", k), acc_idx[k], exp_ord[k]);
            check_val($sformatf("t4_data%0d", k), st_data[k], exp_dat[k]);
        end

        // 5: reset while waiting for the core to finish
        clear_logs();
        pq[2].push_back({1'b1, 8'h5A});
        drive_heads();
        c = 0;
        while (c < 50 && !req_ready[2]) begin
            @(negedge clk);
            if (!req_ready[2]) c++;
        end
        check_val("t5_grant2", req_ready[2], 1);
        step();
        void'(pq[2].pop_front());
        drive_heads();
        repeat (4) step();
        check_val("t5_busy_pre", busy, 1);
        check_val("t5_core_busy", tx_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("t5_busy", busy, 0);
        check_val("t5_tx_start", tx_start, 0);
        check_val("t5_grant_id", grant_id, 0);
        check_val("t5_req_ready", req_ready, 0);
        clear_logs();
        pq[1].push_back({1'b1, 8'h61});
        pq[3].push_back({1'b1, 8'h63});
        run_traffic("t5", 2, 800);
        check_val("t5_order0", acc_idx[0], 1);
        check_val("t5_order1", acc_idx[1], 3);

        // 6: pointer wrap from 3 back to 0, then on to 1
        clear_logs();
        pq[2].push_back({1'b1, 8'h22});
        run_traffic("t6a", 1, 400);
        pq[0].push_back({1'b1, 8'h20});
        run_traffic("t6b", 1, 400);
        check_val("t6_wrap_grant", st_id[1], 0);
        pq[0].push_back({1'b1, 8'h20});
        pq[1].push_back({1'b1, 8'h21});
        pq[3].push_back({1'b1, 8'h23});
        run_traffic("t6c", 3, 1000);
        check_val("t6_after_wrap0", acc_idx[2], 1);
        check_val("t6_after_wrap1", acc_idx[3], 3);
        check_val("t6_after_wrap2", acc_idx[4], 0);

        check_val("onehot_ready", onehot_err, 0);
        check_val("tx_data_stable", stab_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
